// File: rtl/layer1_maxpool_stream.sv
// 2x2 / stride-2 signed max-pool over CH parallel channels, streamed in raster order.
// Feeds the layer-1 feature-map store: pooled beats, its write enable and a pool-done pulse.
module layer1_maxpool_stream #(
    parameter int IN_WIDTH  = 8,
    parameter int IN_HEIGHT = 8,
    parameter int CH        = 16,
    parameter int DW        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pre_vsync,
    input  logic             pre_href,
    input  logic [CH*DW-1:0] pre_data,
    output logic             post_vsync,
    output logic             post_href,
    output logic [CH*DW-1:0] post_data,
    output logic             fm_wea,
    output logic             pool_done
);

    localparam int CW = (IN_WIDTH > 2) ? $clog2(IN_WIDTH) : 2;
    localparam int RW = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
    localparam int IW = CW - 1;
    localparam int LB = 1 << IW;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    generate
        if ((IN_WIDTH % 2 != 0) || (IN_WIDTH < 2) || (IN_HEIGHT % 2 != 0) || (IN_HEIGHT < 2)) begin : g_bad_geometry
            $error("layer1_maxpool_stream: IN_WIDTH and IN_HEIGHT must be even and >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CW-1:0]      col_r;
    logic [RW-1:0]      row_r;
    logic [CH*DW-1:0]   h_reg_r;
    logic [CH*DW-1:0]   linebuf_r [LB];
    logic [IW-1:0]      lb_idx_s;
    logic [CH*DW-1:0]   hmax_s;
    logic [CH*DW-1:0]   vmax_s;
    logic               vsync_rise_s;
    logic               accept_s;
    logic               last_beat_s;
    logic               store_s;
    logic               emit_s;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] m;
        if ($signed(a) >= $signed(b)) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

    // post_vsync doubles as the delayed vsync used for edge detection
    assign vsync_rise_s = pre_vsync & ~post_vsync;
    assign accept_s     = pre_href & (state_r == RUN) & ~vsync_rise_s;
    assign last_beat_s  = (col_r == COL_LAST) && (row_r == ROW_LAST);
    assign lb_idx_s     = col_r[CW-1:1];
    assign store_s      = accept_s & col_r[0] & ~row_r[0];
    assign emit_s       = accept_s & col_r[0] & row_r[0];

    // Per-lane horizontal pair max and vertical max against the stored upper row
    always_comb begin
        hmax_s = '0;
        vmax_s = '0;
        for (int k = 0; k < CH; k++) begin
            hmax_s[k*DW +: DW] = smax(h_reg_r[k*DW +: DW], pre_data[k*DW +: DW]);
            vmax_s[k*DW +: DW] = smax(linebuf_r[lb_idx_s][k*DW +: DW], hmax_s[k*DW +: DW]);
        end
    end

    // Frame FSM next state; a vsync edge restarts from any state
    always_comb begin
        state_s = state_r;
        if (vsync_rise_s) begin
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE: state_s = IDLE;
                RUN: begin
                    if (accept_s && last_beat_s) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Raster position counters, advancing on accepted beats only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (vsync_rise_s) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Left pixel of each horizontal pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_reg_r <= '0;
        end else if (accept_s && !col_r[0]) begin
            h_reg_r <= pre_data;
        end
    end

    // Upper-row pair maxima, one entry per output column; contents need no reset
    always_ff @(posedge clk) begin
        if (store_s) begin
            linebuf_r[lb_idx_s] <= hmax_s;
        end
    end

    // Pooled output beat, registered one cycle after the window's last pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_href <= 1'b0;
            post_data <= '0;
        end else begin
            post_href <= emit_s;
            if (emit_s) begin
                post_data <= vmax_s;
            end
        end
    end

    // Frame handshake to the feature-map store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_vsync <= 1'b0;
            pool_done  <= 1'b0;
            fm_wea     <= 1'b0;
        end else begin
            post_vsync <= pre_vsync;
            pool_done  <= (state_r == DONE) && !vsync_rise_s;
            if (vsync_rise_s) begin
                fm_wea <= 1'b1;
            end else if (state_r == DONE) begin
                fm_wea <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer1_maxpool_stream.sv
// Directed bench for layer1_maxpool_stream on a 4x4 frame with 16 lanes of 16 bits.
module tb_layer1_maxpool_stream;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int CH   = 16;
    localparam int DW   = 16;
    localparam int PW   = CH * DW;
    localparam int NPIX = W * H;
    localparam int NOUT = NPIX / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pre_vsync;
    logic          pre_href;
    logic [PW-1:0] pre_data;
    logic          post_vsync;
    logic          post_href;
    logic [PW-1:0] post_data;
    logic          fm_wea;
    logic          pool_done;

    layer1_maxpool_stream #(
        .IN_WIDTH (W),
        .IN_HEIGHT(H),
        .CH       (CH),
        .DW       (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pre_vsync (pre_vsync),
        .pre_href  (pre_href),
        .pre_data  (pre_data),
        .post_vsync(post_vsync),
        .post_href (post_href),
        .post_data (post_data),
        .fm_wea    (fm_wea),
        .pool_done (pool_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [PW-1:0] pix     [NPIX];
    logic [PW-1:0] exp_out [NOUT];
    logic [PW-1:0] exp1    [NOUT];
    int            bcyc    [NPIX];
    int            b1      [NPIX];
    int            vs_cyc;
    int            a_vs;
    logic [PW-1:0] out_q  [$];
    int            ocyc_q [$];
    int            done_q [$];
    bit            fm_hist [0:4095];

    // Output monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (cyc < 4096) fm_hist[cyc] = fm_wea;
        if (post_href === 1'b1) begin
            out_q.push_back(post_data);
            ocyc_q.push_back(cyc);
        end
        if (pool_done === 1'b1) done_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick(input logic v, input logic h, input logic [PW-1:0] d);
        @(negedge clk);
        pre_vsync = v;
        pre_href  = h;
        pre_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    task automatic clear_q();
        out_q.delete();
        ocyc_q.delete();
        done_q.delete();
    endtask

    // Vsync pulse then nb beats; pre_vsync must be low on entry
    task automatic run_frame(input int nb, input int gaps, input logic vs_hold);
        tick(1'b1, 1'b0, '0);
        vs_cyc = cyc;
        for (int i = 0; i < nb; i++) begin
            int g;
            g = (gaps > 0) ? int'($urandom_range(gaps, 0)) : 0;
            for (int j = 0; j < g; j++) tick(vs_hold, 1'b0, '0);
            tick(vs_hold, 1'b1, pix[i]);
            bcyc[i] = cyc;
        end
        tick(vs_hold, 1'b0, '0);
    endtask

    function automatic logic [PW-1:0] rep(input logic [DW-1:0] v);
        return {CH{v}};
    endfunction

    function automatic void fill(input int mode, input int off);
        int v;
        for (int i = 0; i < NPIX; i++) begin
            for (int k = 0; k < CH; k++) begin
                v = (mode == 0) ? (i + off) : (i + off) * (k + 1);
                if (mode == 1 && k == 3) v = -v;
                pix[i][k*DW +: DW] = 16'(v);
            end
        end
    endfunction

    function automatic int comp_idx(input int o);
        return (2 * (o / (W / 2)) + 1) * W + 2 * (o % (W / 2)) + 1;
    endfunction

    // Reference: signed max of the four window pixels, lane by lane
    function automatic void build_exp();
        int base;
        logic [DW-1:0] m;
        logic [DW-1:0] x;
        int idx [4];
        for (int o = 0; o < NOUT; o++) begin
            base = 2 * (o / (W / 2)) * W + 2 * (o % (W / 2));
            idx[0] = base; idx[1] = base + 1; idx[2] = base + W; idx[3] = base + W + 1;
            for (int k = 0; k < CH; k++) begin
                m = pix[idx[0]][k*DW +: DW];
                for (int j = 1; j < 4; j++) begin
                    x = pix[idx[j]][k*DW +: DW];
                    if ($signed(x) > $signed(m)) m = x;
                end
                exp_out[o][k*DW +: DW] = m;
            end
        end
    endfunction

    task automatic check_frame(input string tag);
        check_eq({tag, ".n_out"}, PW'(out_q.size()), PW'(NOUT));
        for (int o = 0; o < NOUT; o++) begin
            if (o < out_q.size()) begin
                check_eq($sformatf("%s.data%0d", tag, o), out_q[o], exp_out[o]);
                check_eq($sformatf("%s.lat%0d", tag, o), PW'(ocyc_q[o]), PW'(bcyc[comp_idx(o)] + 1));
            end
        end
        check_eq({tag, ".n_done"}, PW'(done_q.size()), PW'(1));
        if (done_q.size() > 0) check_eq({tag, ".done_cyc"}, PW'(done_q[0]), PW'(bcyc[NPIX-1] + 2));
    endtask

    task automatic check_fm(input string tag, input int from);
        int z;
        z = 0;
        for (int c = from; c <= bcyc[NPIX-1] + 1; c++) if (!fm_hist[c]) z++;
        check_eq({tag, ".fm_gaps"}, PW'(z), PW'(0));
        check_eq({tag, ".fm_clr"}, PW'(fm_hist[bcyc[NPIX-1] + 2]), PW'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pre_vsync = 1'b0; pre_href = 1'b0; pre_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst.post_href", PW'(post_href), PW'(0));
        check_eq("rst.post_data", post_data, '0);
        check_eq("rst.fm_wea", PW'(fm_wea), PW'(0));
        check_eq("rst.pool_done", PW'(pool_done), PW'(0));
        check_eq("rst.post_vsync", PW'(post_vsync), PW'(0));
        rst = 1'b0;
        idle(2);
        clear_q();

        // T1: raster index data, continuous beats
        fill(0, 0);
        exp_out[0] = rep(16'd5); exp_out[1] = rep(16'd7);
        exp_out[2] = rep(16'd13); exp_out[3] = rep(16'd15);
        run_frame(NPIX, 0, 1'b0);
        idle(3);
        check_frame("t1");
        check_fm("t1", vs_cyc + 1);
        clear_q();

        // T2: signed windows and an all-minimum tie
        for (int i = 0; i < NPIX; i++) pix[i] = rep(16'(i));
        pix[0] = rep(16'hFFFD); pix[1] = rep(16'hFFF9);
        pix[4] = rep(16'hFFFF); pix[5] = rep(16'h8000);
        pix[2] = rep(16'h8000); pix[3] = rep(16'h8000);
        pix[6] = rep(16'h8000); pix[7] = rep(16'h8000);
        exp_out[0] = rep(16'hFFFF); exp_out[1] = rep(16'h8000);
        exp_out[2] = rep(16'd13);   exp_out[3] = rep(16'd15);
        run_frame(NPIX, 0, 1'b0);
        idle(3);
        check_frame("t2");
        clear_q();

        // T3: T1 data with random href gaps
        fill(0, 0);
        exp_out[0] = rep(16'd5); exp_out[1] = rep(16'd7);
        exp_out[2] = rep(16'd13); exp_out[3] = rep(16'd15);
        run_frame(NPIX, 3, 1'b0);
        idle(3);
        check_frame("t3");
        check_fm("t3", vs_cyc + 1);
        clear_q();

        // T4: frame A aborted after 6 beats, then full frame B
        fill(0, 0);
        run_frame(6, 0, 1'b0);
        a_vs = vs_cyc;
        idle(1);
        check_eq("t4.a_outs", PW'(out_q.size()), PW'(1));
        clear_q();
        fill(0, 100);
        exp_out[0] = rep(16'd105); exp_out[1] = rep(16'd107);
        exp_out[2] = rep(16'd113); exp_out[3] = rep(16'd115);
        run_frame(NPIX, 0, 1'b0);
        idle(3);
        check_frame("t4");
        check_fm("t4", a_vs + 1);
        clear_q();

        // T5: async reset mid-frame, stray beats, then a clean frame
        fill(0, 0);
        run_frame(9, 0, 1'b0);
        check_eq("t5.pre_fm", PW'(fm_wea), PW'(1));
        check_eq("t5.pre_data", post_data, rep(16'd7));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("t5.rst_fm", PW'(fm_wea), PW'(0));
        check_eq("t5.rst_data", post_data, '0);
        check_eq("t5.rst_href", PW'(post_href), PW'(0));
        check_eq("t5.rst_done", PW'(pool_done), PW'(0));
        #1 rst = 1'b0;
        clear_q();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, pix[i]);
        idle(2);
        check_eq("t5.stray_outs", PW'(out_q.size()), PW'(0));
        check_eq("t5.stray_fm", PW'(fm_wea), PW'(0));
        exp_out[0] = rep(16'd5); exp_out[1] = rep(16'd7);
        exp_out[2] = rep(16'd13); exp_out[3] = rep(16'd15);
        run_frame(NPIX, 0, 1'b0);
        idle(3);
        check_frame("t5");
        clear_q();

        // T6: independent lanes, back-to-back frames with a 1-cycle vsync gap
        fill(1, 0);
        build_exp();
        for (int o = 0; o < NOUT; o++) exp1[o] = exp_out[o];
        run_frame(NPIX, 0, 1'b1);
        for (int i = 0; i < NPIX; i++) b1[i] = bcyc[i];
        tick(1'b0, 1'b0, '0);
        fill(1, 3);
        build_exp();
        run_frame(NPIX, 0, 1'b0);
        idle(3);
        check_eq("t6.n_out", PW'(out_q.size()), PW'(2 * NOUT));
        for (int o = 0; o < NOUT; o++) begin
            if (o + NOUT < out_q.size()) begin
                check_eq($sformatf("t6.f1_data%0d", o), out_q[o], exp1[o]);
                check_eq($sformatf("t6.f2_data%0d", o), out_q[o + NOUT], exp_out[o]);
            end
        end
        if (out_q.size() > 3) begin
            check_eq("t6.lane3_hand", PW'(out_q[3][3*DW +: DW]), PW'(16'hFFD8));
            check_eq("t6.lane15_hand", PW'(out_q[3][15*DW +: DW]), PW'(16'h00F0));
        end
        check_eq("t6.n_done", PW'(done_q.size()), PW'(2));
        if (done_q.size() > 1) begin
            check_eq("t6.done1", PW'(done_q[0]), PW'(b1[NPIX-1] + 2));
            check_eq("t6.done2", PW'(done_q[1]), PW'(bcyc[NPIX-1] + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
